// File: rtl/is_stream_rx.sv
// Serial instruction bus receiver: tracks the word-cycle bit time, deserializes
// the sync-framed instruction and locks after two good frames. Option: IS_RX_DECODE_EN.
module is_stream_rx #(
   parameter int unsigned WORD_BITS  = 56,
   parameter int unsigned INSTR_BITS = 10,
   parameter int unsigned SYNC_START = 45
) (
   input  logic                  cfst,
   input  logic                  rstb,
   input  logic                  bit_en,
   input  logic                  sync,
   input  logic                  is,
   output logic [INSTR_BITS-1:0] instr,
   output logic                  instr_vld,
   output logic [5:0]            bit_time,
   output logic                  locked,
   output logic                  sync_err
`ifdef IS_RX_DECODE_EN
   ,
   output logic                  cls_jsb,
   output logic                  cls_branch,
   output logic                  cls_arith,
   output logic                  cls_misc
`endif
);

   localparam int unsigned LW = $clog2(INSTR_BITS + 1);

   localparam logic [1:0] ST_HUNT  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_LOCK  = 2'd2;

   localparam logic [5:0]    LAST_BT  = 6'(WORD_BITS - 1);
   localparam logic [5:0]    START_BT = 6'(SYNC_START);
   localparam logic [LW-1:0] FULL_LEN = LW'(INSTR_BITS);

   logic [1:0]            state, state_n;
   logic                  sync_q;
   logic [LW-1:0]         len, len_n;
   logic [INSTR_BITS-1:0] sh, sh_n;
   logic                  frame_bad, frame_bad_n;
   logic                  load_q;
   logic [5:0]            bt_n, bt_inc;
   logic                  rise, high, fall;
   logic                  err, good;

   assign rise   = sync & ~sync_q;
   assign high   = sync & sync_q;
   assign fall   = ~sync & sync_q;
   assign locked = (state == ST_LOCK);

   always_comb begin
      bt_inc      = (bit_time == LAST_BT) ? '0 : bit_time + 6'd1;
      bt_n        = bt_inc;
      state_n     = state;
      len_n       = len;
      sh_n        = sh;
      frame_bad_n = frame_bad;
      err         = 1'b0;
      good        = 1'b0;
      if (rise) begin
         len_n       = LW'(1);
         sh_n        = {is, sh[INSTR_BITS-1:1]};
         frame_bad_n = 1'b0;
         if (state == ST_HUNT)
            bt_n = (START_BT == LAST_BT) ? '0 : START_BT + 6'd1;
         else if (bit_time != START_BT)
            err = 1'b1;
      end else if (high && !frame_bad) begin
         if (len == FULL_LEN)
            err = 1'b1;
         else begin
            len_n = len + LW'(1);
            sh_n  = {is, sh[INSTR_BITS-1:1]};
         end
      end else if (fall && !frame_bad) begin
         if (len == FULL_LEN)
            good = 1'b1;
         else
            err = 1'b1;
      end
      if (state != ST_HUNT && bit_time == START_BT && !sync)
         err = 1'b1;
      // an errored frame is ignored until the next rise; errors override a good fall
      if (err) begin
         state_n     = ST_HUNT;
         frame_bad_n = 1'b1;
         good        = 1'b0;
      end else if (good) begin
         state_n = (state == ST_HUNT) ? ST_CHECK : ST_LOCK;
      end
   end

   always_ff @(posedge cfst or negedge rstb) begin
      if (!rstb) begin
         state     <= ST_HUNT;
         bit_time  <= '0;
         sync_q    <= 1'b0;
         len       <= '0;
         sh        <= '0;
         frame_bad <= 1'b0;
         load_q    <= 1'b0;
         instr     <= '0;
         instr_vld <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         instr_vld <= 1'b0;
         sync_err  <= 1'b0;
         load_q    <= 1'b0;
         if (load_q) begin
            instr     <= sh;
            instr_vld <= 1'b1;
         end
         if (bit_en) begin
            state     <= state_n;
            bit_time  <= bt_n;
            sync_q    <= sync;
            len       <= len_n;
            sh        <= sh_n;
            frame_bad <= frame_bad_n;
            sync_err  <= err;
            load_q    <= good;
         end
      end
   end

`ifdef IS_RX_DECODE_EN
   always_ff @(posedge cfst or negedge rstb) begin
      if (!rstb) begin
         cls_jsb    <= 1'b0;
         cls_branch <= 1'b0;
         cls_arith  <= 1'b0;
         cls_misc   <= 1'b0;
      end else if (load_q) begin
         cls_jsb    <= (sh[1:0] == 2'b01);
         cls_branch <= (sh[1:0] == 2'b11);
         cls_arith  <= (sh[1:0] == 2'b10);
         cls_misc   <= (sh[1:0] == 2'b00);
      end
   end
`endif

endmodule
